// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg: flow opcodes, SR bit indices and flow FSM state encodings.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

  localparam logic [2:0] OP_TRAP = 3'd0;
  localparam logic [2:0] OP_NOP  = 3'd1;
  localparam logic [2:0] OP_JMP  = 3'd2;
  localparam logic [2:0] OP_JZ   = 3'd3;
  localparam logic [2:0] OP_JS   = 3'd4;
  localparam logic [2:0] OP_JZS  = 3'd5;
  localparam logic [2:0] OP_LSR  = 3'd6;
  localparam logic [2:0] OP_XSR  = 3'd7;

  localparam int SR_Z = 0;
  localparam int SR_S = 1;
  localparam int SR_C = 2;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_BUBBLE = 2'd1,
    ST_TRAP   = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/flow_ctrl_unit_if.sv
// ---------------------------------------------------------------------------
// flow_ctrl_unit_if: op handshake, ALU flag and PC/SR status bundle.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface flow_ctrl_unit_if #(
  parameter int ADDR_W = 20
);
  logic [2:0]        flg_we;
  logic              alu_zero;
  logic              alu_sign;
  logic              alu_carry;
  logic              op_valid;
  logic              op_ready;
  logic [2:0]        op_code;
  logic [ADDR_W-1:0] op_target;
  logic [2:0]        op_sr;
  logic [ADDR_W-1:0] pc;
  logic              redirect;
  logic [2:0]        sr;
  logic              trapped;
  logic              trap_ack;

  modport master (
    output flg_we, alu_zero, alu_sign, alu_carry, op_valid, op_code, op_target, op_sr, trap_ack,
    input  op_ready, pc, redirect, sr, trapped
  );

  modport slave (
    input  flg_we, alu_zero, alu_sign, alu_carry, op_valid, op_code, op_target, op_sr, trap_ack,
    output op_ready, pc, redirect, sr, trapped
  );
endinterface

`default_nettype wire

// File: rtl/flow_ctrl_unit_status_reg.sv
// ---------------------------------------------------------------------------
// status_reg: 3-bit {C,S,Z} register, per-bit priority LSR > XSR > ALU write.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module status_reg (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       lsr_i,
  input  wire logic       xsr_i,
  input  wire logic [2:0] op_sr_i,
  input  wire logic [2:0] flg_we_i,
  input  wire logic [2:0] alu_flags_i,
  output logic      [2:0] sr_q_o,
  output logic      [2:0] sr_next_o
);

  logic [2:0] sr_q;
  logic [2:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    for (int b = 0; b < 3; b++) begin
      if (lsr_i)            sr_d[b] = op_sr_i[b];
      else if (xsr_i)       sr_d[b] = sr_q[b] ^ op_sr_i[b];
      else if (flg_we_i[b]) sr_d[b] = alu_flags_i[b];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) sr_q <= 3'b000;
    else     sr_q <= sr_d;
  end

  assign sr_q_o    = sr_q;
  assign sr_next_o = sr_d;

endmodule

`default_nettype wire

// File: rtl/flow_ctrl_unit.sv
// ---------------------------------------------------------------------------
// flow_ctrl_unit: PC, status register, conditional jumps and trap handling.
// Option macro: FLAG_BYPASS_EN (jump conditions see same-cycle ALU flags).  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module flow_ctrl_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 20,
  parameter logic [ADDR_W-1:0] RESET_PC = 20'h00000,
  parameter logic [ADDR_W-1:0] TRAP_VEC = 20'hFFF00
) (
  input wire logic        clk,
  input wire logic        rst,
  flow_ctrl_unit_if.slave fc
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              redirect_q, redirect_d;
  logic [2:0]        sr_q, sr_next, cond_sr, alu_flags;
  logic              accept, taken, lsr, xsr;

  assign fc.op_ready = (state_q == ST_RUN) && !rst;
  assign accept      = fc.op_valid && fc.op_ready;
  assign lsr         = accept && (fc.op_code == OP_LSR);
  assign xsr         = accept && (fc.op_code == OP_XSR);

  always_comb begin
    alu_flags       = 3'b000;
    alu_flags[SR_Z] = fc.alu_zero;
    alu_flags[SR_S] = fc.alu_sign;
    alu_flags[SR_C] = fc.alu_carry;
  end

  status_reg u_status_reg (
    .clk         (clk),
    .rst         (rst),
    .lsr_i       (lsr),
    .xsr_i       (xsr),
    .op_sr_i     (fc.op_sr),
    .flg_we_i    (fc.flg_we),
    .alu_flags_i (alu_flags),
    .sr_q_o      (sr_q),
    .sr_next_o   (sr_next)
  );

`ifdef FLAG_BYPASS_EN
  assign cond_sr = sr_next;
`else
  assign cond_sr = sr_q;
`endif

  always_comb begin
    taken = 1'b0;
    case (fc.op_code)
      OP_JMP:  taken = 1'b1;
      OP_JZ:   taken = cond_sr[SR_Z];
      OP_JS:   taken = cond_sr[SR_S];
      OP_JZS:  taken = cond_sr[SR_Z] | cond_sr[SR_S];
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redirect_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (accept) begin
          if (fc.op_code == OP_TRAP) begin
            pc_d       = TRAP_VEC;
            redirect_d = 1'b1;
            state_d    = ST_TRAP;
          end else if (taken) begin
            pc_d       = fc.op_target;
            redirect_d = 1'b1;
            state_d    = ST_BUBBLE;
          end else begin
            pc_d = pc_q + ADDR_W'(1);
          end
        end
      end
      ST_BUBBLE: state_d = ST_RUN;
      ST_TRAP:   if (fc.trap_ack) state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      redirect_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
    end
  end

  assign fc.pc       = pc_q;
  assign fc.redirect = redirect_q;
  assign fc.sr       = sr_q;
  assign fc.trapped  = (state_q == ST_TRAP);

endmodule

`default_nettype wire

// File: tb/tb_flow_ctrl_unit.sv
// ---------------------------------------------------------------------------
// tb_flow_ctrl_unit: directed self-checking bench for flow_ctrl_unit.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_flow_ctrl_unit;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  flow_ctrl_unit_if #(.ADDR_W(20)) bus ();

  flow_ctrl_unit #(
    .ADDR_W   (20),
    .RESET_PC (20'h00000),
    .TRAP_VEC (20'hFFF00)
  ) dut (
    .clk (clk),
    .rst (rst),
    .fc  (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] code, input logic [19:0] tgt, input logic [2:0] srv);
    bus.op_valid  = 1'b1;
    bus.op_code   = code;
    bus.op_target = tgt;
    bus.op_sr     = srv;
    tick();
    bus.op_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    n_cmp++; if (bus.op_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready0: got %b want 0", bus.op_ready); end
    tick();
    n_cmp++; if (bus.pc !== 20'h00000) begin n_fail++; $display("FAIL reset_pc: got %h want 00000", bus.pc); end
    n_cmp++; if (bus.sr !== 3'b000) begin n_fail++; $display("FAIL reset_sr: got %b want 000", bus.sr); end
    n_cmp++; if (bus.trapped !== 1'b0) begin n_fail++; $display("FAIL reset_trapped: got %b want 0", bus.trapped); end
    n_cmp++; if (bus.redirect !== 1'b0) begin n_fail++; $display("FAIL reset_redirect: got %b want 0", bus.redirect); end
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.op_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready1: got %b want 1", bus.op_ready); end
  endtask

  task automatic test_jumps();
    issue(OP_LSR, 20'h0, 3'b001);
    n_cmp++; if (bus.sr !== 3'b001) begin n_fail++; $display("FAIL lsr_sr: got %b want 001", bus.sr); end
    issue(OP_JS, 20'h00077, 3'b000);
    n_cmp++; if (bus.pc !== 20'h00002) begin n_fail++; $display("FAIL js_not_taken_pc: got %h want 00002", bus.pc); end
    n_cmp++; if (bus.redirect !== 1'b0) begin n_fail++; $display("FAIL js_not_taken_redir: got %b want 0", bus.redirect); end
    issue(OP_JZ, 20'h00040, 3'b000);
    n_cmp++; if (bus.pc !== 20'h00040) begin n_fail++; $display("FAIL jz_taken_pc: got %h want 00040", bus.pc); end
    n_cmp++; if (bus.redirect !== 1'b1) begin n_fail++; $display("FAIL jz_taken_redir: got %b want 1", bus.redirect); end
    n_cmp++; if (bus.op_ready !== 1'b0) begin n_fail++; $display("FAIL jz_bubble_ready: got %b want 0", bus.op_ready); end
    tick();
    n_cmp++; if (bus.redirect !== 1'b0) begin n_fail++; $display("FAIL jz_redir_pulse: got %b want 0", bus.redirect); end
    n_cmp++; if (bus.op_ready !== 1'b1) begin n_fail++; $display("FAIL jz_after_bubble_ready: got %b want 1", bus.op_ready); end
    n_cmp++; if (bus.pc !== 20'h00040) begin n_fail++; $display("FAIL jz_pc_hold: got %h want 00040", bus.pc); end
    issue(OP_LSR, 20'h0, 3'b000);
    issue(OP_JZ, 20'h00080, 3'b000);
    n_cmp++; if (bus.pc !== 20'h00042) begin n_fail++; $display("FAIL jz_not_taken_pc: got %h want 00042", bus.pc); end
    n_cmp++; if (bus.redirect !== 1'b0) begin n_fail++; $display("FAIL jz_not_taken_redir: got %b want 0", bus.redirect); end
  endtask

  task automatic test_bypass();
    logic [19:0] exp_pc;
    logic        exp_rd;
`ifdef FLAG_BYPASS_EN
    exp_pc = 20'h00100;
    exp_rd = 1'b1;
`else
    exp_pc = 20'h00043;
    exp_rd = 1'b0;
`endif
    bus.flg_we   = 3'b001;
    bus.alu_zero = 1'b1;
    issue(OP_JZ, 20'h00100, 3'b000);
    bus.flg_we   = 3'b000;
    bus.alu_zero = 1'b0;
    n_cmp++; if (bus.pc !== exp_pc) begin n_fail++; $display("FAIL bypass_pc: got %h want %h", bus.pc, exp_pc); end
    n_cmp++; if (bus.redirect !== exp_rd) begin n_fail++; $display("FAIL bypass_redir: got %b want %b", bus.redirect, exp_rd); end
    n_cmp++; if (bus.sr !== 3'b001) begin n_fail++; $display("FAIL bypass_sr: got %b want 001", bus.sr); end
    tick();
    n_cmp++; if (bus.pc !== exp_pc) begin n_fail++; $display("FAIL idle_pc_hold: got %h want %h", bus.pc, exp_pc); end
    n_cmp++; if (bus.op_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got %b want 1", bus.op_ready); end
  endtask

  task automatic test_sr_priority();
    bus.flg_we = 3'b111;
    issue(OP_LSR, 20'h0, 3'b101);
    bus.flg_we = 3'b000;
    n_cmp++; if (bus.sr !== 3'b101) begin n_fail++; $display("FAIL lsr_over_alu: got %b want 101", bus.sr); end
    issue(OP_XSR, 20'h0, 3'b111);
    n_cmp++; if (bus.sr !== 3'b010) begin n_fail++; $display("FAIL xsr: got %b want 010", bus.sr); end
  endtask

  task automatic test_trap();
    issue(OP_JMP, 20'h00010, 3'b000);
    tick();
    n_cmp++; if (bus.pc !== 20'h00010) begin n_fail++; $display("FAIL jmp_pc: got %h want 00010", bus.pc); end
    issue(OP_TRAP, 20'h0, 3'b000);
    n_cmp++; if (bus.pc !== 20'hFFF00) begin n_fail++; $display("FAIL trap_pc: got %h want fff00", bus.pc); end
    n_cmp++; if (bus.trapped !== 1'b1) begin n_fail++; $display("FAIL trap_trapped: got %b want 1", bus.trapped); end
    n_cmp++; if (bus.redirect !== 1'b1) begin n_fail++; $display("FAIL trap_redir: got %b want 1", bus.redirect); end
    bus.op_valid  = 1'b1;
    bus.op_code   = OP_NOP;
    bus.flg_we    = 3'b100;
    bus.alu_carry = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (bus.pc !== 20'hFFF00 || bus.trapped !== 1'b1 || bus.op_ready !== 1'b0) begin
        n_fail++; $display("FAIL trap_hold[%0d]: pc %h trapped %b ready %b want fff00 1 0", i, bus.pc, bus.trapped, bus.op_ready);
      end
    end
    bus.op_valid  = 1'b0;
    bus.flg_we    = 3'b000;
    bus.alu_carry = 1'b0;
    n_cmp++; if (bus.sr !== 3'b110) begin n_fail++; $display("FAIL trap_alu_write: got %b want 110", bus.sr); end
    bus.trap_ack = 1'b1;
    tick();
    n_cmp++; if (bus.trapped !== 1'b0) begin n_fail++; $display("FAIL ack_trapped: got %b want 0", bus.trapped); end
    n_cmp++; if (bus.pc !== 20'hFFF00) begin n_fail++; $display("FAIL ack_pc: got %h want fff00", bus.pc); end
    n_cmp++; if (bus.op_ready !== 1'b1) begin n_fail++; $display("FAIL ack_ready: got %b want 1", bus.op_ready); end
    tick();
    bus.trap_ack = 1'b0;
    n_cmp++; if (bus.trapped !== 1'b0) begin n_fail++; $display("FAIL ack_in_run: got %b want 0", bus.trapped); end
  endtask

  task automatic test_wrap_and_reset();
    issue(OP_JMP, 20'hFFFFF, 3'b000);
    tick();
    issue(OP_NOP, 20'h0, 3'b000);
    n_cmp++; if (bus.pc !== 20'h00000) begin n_fail++; $display("FAIL pc_wrap: got %h want 00000", bus.pc); end
    n_cmp++; if (bus.redirect !== 1'b0) begin n_fail++; $display("FAIL wrap_redir: got %b want 0", bus.redirect); end
    issue(OP_LSR, 20'h0, 3'b010);
    issue(OP_JZS, 20'h00200, 3'b000);
    n_cmp++; if (bus.pc !== 20'h00200) begin n_fail++; $display("FAIL jzs_pc: got %h want 00200", bus.pc); end
    n_cmp++; if (bus.redirect !== 1'b1) begin n_fail++; $display("FAIL jzs_redir: got %b want 1", bus.redirect); end
    rst = 1'b1;
    tick();
    n_cmp++; if (bus.pc !== 20'h00000 || bus.sr !== 3'b000 || bus.redirect !== 1'b0 || bus.trapped !== 1'b0 || bus.op_ready !== 1'b0) begin
      n_fail++; $display("FAIL bubble_reset: pc %h sr %b redir %b trapped %b ready %b want 00000 000 0 0 0",
                         bus.pc, bus.sr, bus.redirect, bus.trapped, bus.op_ready);
    end
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.op_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b want 1", bus.op_ready); end
  endtask

  initial begin
    bus.flg_we    = 3'b000;
    bus.alu_zero  = 1'b0;
    bus.alu_sign  = 1'b0;
    bus.alu_carry = 1'b0;
    bus.op_valid  = 1'b0;
    bus.op_code   = OP_NOP;
    bus.op_target = 20'h0;
    bus.op_sr     = 3'b000;
    bus.trap_ack  = 1'b0;
    test_reset();
    test_jumps();
    test_bypass();
    test_sr_priority();
    test_trap();
    test_wrap_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
